// File: rtl/jt5205_player.sv
`default_nettype none
// ============================================================================
// Module   : jt5205_player
// Purpose  : ADPCM sample sequencer for the JT5205 decoder. Fetches bytes
//            from ROM over an inclusive, wrap-around address range, keeps a
//            two-byte buffer (cur + buf), and presents one nibble on each
//            sample strobe. Drives the decoder reset and reports busy, done
//            and a sticky underrun flag.
// Revision : 1.0  initial release
// ============================================================================
module jt5205_player #(
   parameter int AW       = 16,
   parameter bit HI_FIRST = 1'b1
) (
   input  logic          rst_n,
   input  logic          clk,
   input  logic          start,
   input  logic          stop,
   input  logic [AW-1:0] start_addr,
   input  logic [AW-1:0] end_addr,
   input  logic          sample_cen,
   output logic [AW-1:0] rom_addr,
   output logic          rom_cs,
   input  logic [7:0]    rom_data,
   input  logic          rom_ok,
   output logic [3:0]    din,
   output logic          dec_rst,
   output logic          busy,
   output logic          done,
   output logic          underrun
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_PLAY  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [AW-1:0] C_ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

   state_t        state_q,    state_d;
   logic [AW-1:0] addr_q,     addr_d;
   logic [AW-1:0] end_q,      end_d;
   logic          cs_q,       cs_d;
   logic [7:0]    cur_q,      cur_d;
   logic          cur_vld_q,  cur_vld_d;
   logic [7:0]    buf_q,      buf_d;
   logic          buf_vld_q,  buf_vld_d;
   logic          nib_q,      nib_d;      // 0: next nibble is the first of cur
   logic [3:0]    din_q,      din_d;
   logic          dec_rst_q,  dec_rst_d;
   logic          busy_q,     busy_d;
   logic          done_q,     done_d;
   logic          underrun_q, underrun_d;

   logic          accept;      // ROM byte handed over this cycle
   logic          byte_taken;  // accepted byte already routed by the strobe path
   logic          last_byte;   // the request in flight is for the final address
   logic [3:0]    cur_nib;

   // Nibble of cur that the next strobe will present
   always_comb begin
      cur_nib = ((nib_q == 1'b0) == HI_FIRST) ? cur_q[7:4] : cur_q[3:0];
   end

   // Next-state, datapath and output computation for the sequencer
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      end_d      = end_q;
      cs_d       = cs_q;
      cur_d      = cur_q;
      cur_vld_d  = cur_vld_q;
      buf_d      = buf_q;
      buf_vld_d  = buf_vld_q;
      nib_d      = nib_q;
      din_d      = din_q;
      dec_rst_d  = dec_rst_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      underrun_d = underrun_q;
      byte_taken = 1'b0;
      accept     = cs_q && rom_ok;
      last_byte  = (addr_q == end_q);

      if (stop) begin
         // Abort wins over everything, including a simultaneous start;
         // any rom_ok in this cycle is dropped with the request.
         state_d   = ST_IDLE;
         cs_d      = 1'b0;
         dec_rst_d = 1'b1;
         busy_d    = 1'b0;
         din_d     = 4'd0;
         cur_vld_d = 1'b0;
         buf_vld_d = 1'b0;
         nib_d     = 1'b0;
      end else if (start) begin
         // (Re)start: abandon any fetch in flight, first request next cycle
         state_d    = ST_PRIME;
         addr_d     = start_addr;
         end_d      = end_addr;
         cs_d       = 1'b0;
         cur_vld_d  = 1'b0;
         buf_vld_d  = 1'b0;
         nib_d      = 1'b0;
         din_d      = 4'd0;
         dec_rst_d  = 1'b1;
         busy_d     = 1'b1;
         underrun_d = 1'b0;
      end else begin
         case (state_q)
            ST_PRIME: begin
               if (accept) begin
                  cur_d     = rom_data;
                  cur_vld_d = 1'b1;
                  nib_d     = 1'b0;
                  dec_rst_d = 1'b0;
                  cs_d      = 1'b0;
                  if (last_byte) begin
                     state_d = ST_DRAIN;
                  end else begin
                     addr_d  = addr_q + C_ADDR_ONE;
                     state_d = ST_PLAY;
                  end
               end else begin
                  cs_d = 1'b1;
               end
            end

            ST_PLAY, ST_DRAIN: begin
               if (sample_cen) begin
                  if (cur_vld_q) begin
                     din_d = cur_nib;
                     nib_d = ~nib_q;
                     if (nib_q) begin
                        // Second nibble out: refill cur from buf, or straight
                        // from the ROM if the byte lands right now.
                        if (buf_vld_q) begin
                           cur_d     = buf_q;
                           buf_vld_d = 1'b0;
                        end else if (accept) begin
                           cur_d      = rom_data;
                           byte_taken = 1'b1;
                        end else begin
                           cur_vld_d = 1'b0;
                        end
                     end
                  end else if (state_q == ST_DRAIN) begin
                     // Everything fetched and played: natural end
                     state_d   = ST_IDLE;
                     done_d    = 1'b1;
                     busy_d    = 1'b0;
                     dec_rst_d = 1'b1;
                     din_d     = 4'd0;
                  end else begin
                     underrun_d = 1'b1;
                     din_d      = 4'd0;
                  end
               end

               if (accept) begin
                  cs_d = 1'b0;
                  if (!byte_taken) begin
                     // After an underrun cur is empty and the byte restarts
                     // playback from its first nibble.
                     if (!cur_vld_d) begin
                        cur_d     = rom_data;
                        cur_vld_d = 1'b1;
                        nib_d     = 1'b0;
                     end else begin
                        buf_d     = rom_data;
                        buf_vld_d = 1'b1;
                     end
                  end
                  if (last_byte) begin
                     state_d = ST_DRAIN;
                  end else begin
                     addr_d = addr_q + C_ADDR_ONE;
                  end
               end else if ((state_q == ST_PLAY) && !cs_q && !buf_vld_q) begin
                  cs_d = 1'b1;
               end
            end

            default: begin
               cs_d = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         end_q      <= '0;
         cs_q       <= 1'b0;
         cur_q      <= 8'd0;
         cur_vld_q  <= 1'b0;
         buf_q      <= 8'd0;
         buf_vld_q  <= 1'b0;
         nib_q      <= 1'b0;
         din_q      <= 4'd0;
         dec_rst_q  <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         end_q      <= end_d;
         cs_q       <= cs_d;
         cur_q      <= cur_d;
         cur_vld_q  <= cur_vld_d;
         buf_q      <= buf_d;
         buf_vld_q  <= buf_vld_d;
         nib_q      <= nib_d;
         din_q      <= din_d;
         dec_rst_q  <= dec_rst_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
      end
   end

   assign rom_addr = addr_q;
   assign rom_cs   = cs_q;
   assign din      = din_q;
   assign dec_rst  = dec_rst_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign underrun = underrun_q;

endmodule
`default_nettype wire
